word_serializer: RTL
====================

# word_serializer

Parallel-to-serial front end for the serial parity path. Accepts a WIDTH-bit word over a valid/ready handshake and shifts it out LSB first, one bit per clock. It optionally appends a computed parity bit. Its serial output `x` drives the running-parity generator's `x` input directly, and `x_valid`/`last` frame each word for downstream consumers.

## Interface
Parameters:
- `WIDTH`, 8, data bits per word; legal range 2..32.
- `PAR_EN`, 1, 1 = append one parity bit after the data bits; 0 = data bits only.
- `PAR_ODD`, 0, 0 = even parity (total ones in frame even); 1 = odd parity.

Ports:
- Clock and reset: one clock; reset is synchronous and active-high.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  reset; synchronous, active-high.
- `din`  in  WIDTH  parallel word; sampled only on an accepted load.
- `load`  in  1  word valid.
- `ready`  out  1  block can accept a word this cycle.
- `x`  out  1  serial bit, registered.
- `x_valid`  out  1  `x` carries a frame bit this cycle, registered.
- `last`  out  1  `x` is the final bit of the frame (the parity bit, or data bit WIDTH-1 when `PAR_EN`=0), registered.
- `busy`  out  1  a frame is in progress (state != IDLE).

## Operation
- States (shared enum): `IDLE`, `SHIFT`, `PARITY`.
- Accept condition: `load && ready` at a rising edge. The word is copied into the shift register, the bit counter is cleared, the parity accumulator is loaded with `PAR_ODD`, and the state goes to `SHIFT`.
- In `SHIFT`, each cycle:
  - `x` = shift register bit 0.
  - The shift register shifts right with zero fill.
  - Parity accumulator ^= bit shifted out.
  - Counter increments.
- Leaving `SHIFT` after WIDTH data bits:
  - `PAR_EN`=1 → `PARITY`.
  - `PAR_EN`=0 → `IDLE`, or straight into a new `SHIFT` if a load is accepted.
- `PARITY` lasts one cycle: `x` = accumulator value, `last`=1. Then → `IDLE`, or a new `SHIFT` on an accepted load.
- `ready` = (state==`IDLE`) OR (final-bit cycle of the current frame), and is forced 0 while `rst`=1. This gives gap-free back-to-back frames.
- `load` while `ready`=0 is ignored; `din` is not sampled.
- Counter width = clog2(WIDTH+1). It never wraps within a frame and is cleared on every accept.
- Parity bit = XOR(data bits) XOR `PAR_ODD`.

## Timing
- Reset values, effective in the cycle after `rst` is sampled high:
  - state `IDLE`, `x`=0, `x_valid`=0, `last`=0, `busy`=0, shift register 0, counter 0.
  - `ready`=1 from the first cycle with `rst` low.
- Latency: a load accepted at edge N puts `din[0]` on `x`, with `x_valid`=1, after edge N.
- Frame length: WIDTH + `PAR_EN` consecutive cycles with `x_valid`=1. `last` is high on exactly the final cycle.
- In `IDLE`: `x`=0, `x_valid`=0, `last`=0.
- Back-to-back: a load accepted on the final-bit cycle gives bit 0 of the new word on the very next cycle. `x_valid` stays 1 and `last` pulses for one cycle only.
- Reset mid-frame: the frame is aborted and the outputs take their reset values the next cycle. A `load` asserted in the same cycle as `rst` is ignored.
- `load` held high continuously: one word is accepted per frame, on each final-bit cycle.

## Structure
- Shared package:
  - state enum (`IDLE`=0, `SHIFT`=1, `PARITY`=2, 2-bit encoding);
  - constants for the `PAR_ODD` polarity values (`PAR_EVEN`=0, `PAR_ODD`=1), which match the parity generator's EVEN/ODD encoding.
- Single module, no sub-module. The shift register, counter, accumulator and FSM are all inline.
- All outputs except `ready` and `busy` are registered. `ready` and `busy` are decoded from registered state only; there is no combinational path from `load` or `din`.

## Test plan
- Even parity, single word (WIDTH=8, `PAR_EN`=1, `PAR_ODD`=0): load 8'hA5 → `x` = 1,0,1,0,0,1,0,1 then parity 0. `x_valid` high for 9 cycles, `last` on cycle 9, `ready` low on cycles 1–8. When chained into the parity generator, its `z` returns to 0 after the frame.
- Odd count: load 8'h07 → bits 1,1,1,0,0,0,0,0 then parity 1. With `PAR_ODD`=1 the same word gives parity 0.
- Back-to-back: `load` held high with 8'h01 then 8'hFF → 18 contiguous `x_valid` cycles. Parity bits are 1 then 0, and `last` pulses on cycles 9 and 18.
- `PAR_EN`=0: load 8'h80 → 7 zeros then 1, with `last` on that final 1. An immediate reload gives no idle cycle.
- Ignored load: pulse `load` with 8'h3C during cycle 4 of an 8'hA5 frame → the frame is unchanged and no second frame follows.
- Mid-frame reset: assert `rst` on cycle 5 of a frame → the next cycle has `x_valid`=0, `busy`=0, `last`=0. `ready`=1 once `rst` drops, and a fresh load of 8'h0F serializes correctly with parity 0.

Source files
------------

// File: rtl/word_serializer_pkg.sv
// Shared types and constants for the serial parity front end.
// Parity polarity values match the running-parity generator's EVEN/ODD encoding.
package word_serializer_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } state_t;

    localparam bit PAR_EVEN = 1'b0;
    localparam bit PAR_ODD  = 1'b1;

endpackage

// File: rtl/word_serializer.sv
// Parallel-to-serial converter: shifts a WIDTH-bit word out LSB first, one bit
// per clock, optionally followed by a parity bit; frames are gap-free when chained.
module word_serializer
    import word_serializer_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter bit PAR_EN  = 1'b1,
    parameter bit PAR_ODD = word_serializer_pkg::PAR_EVEN
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             load,
    output logic             ready,
    output logic             x,
    output logic             x_valid,
    output logic             last,
    output logic             busy
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    // cnt holds the index of the data bit currently presented on x
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_PEN  = CNT_W'(WIDTH - 2);

    state_t           state, state_n;
    logic [WIDTH-1:0] sreg, sreg_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             acc, acc_n;
    logic             x_n, x_valid_n, last_n;
    logic             final_bit;
    logic             accept;

    assign final_bit = (state == PARITY) ||
                       ((state == SHIFT) && (cnt == CNT_LAST) && !PAR_EN);
    assign ready     = !rst && ((state == IDLE) || final_bit);
    assign busy      = (state != IDLE);
    assign accept    = load && ready;

    always_comb begin
        state_n   = state;
        sreg_n    = sreg;
        cnt_n     = cnt;
        acc_n     = acc;
        x_n       = 1'b0;
        x_valid_n = 1'b0;
        last_n    = 1'b0;
        if (accept) begin
            // bit 0 goes straight to x so it appears the cycle after acceptance
            state_n   = SHIFT;
            x_n       = din[0];
            x_valid_n = 1'b1;
            sreg_n    = {1'b0, din[WIDTH-1:1]};
            cnt_n     = '0;
            acc_n     = PAR_ODD ^ din[0];
        end else begin
            case (state)
                SHIFT: begin
                    if (cnt != CNT_LAST) begin
                        x_n       = sreg[0];
                        x_valid_n = 1'b1;
                        sreg_n    = {1'b0, sreg[WIDTH-1:1]};
                        acc_n     = acc ^ sreg[0];
                        cnt_n     = cnt + 1'b1;
                        last_n    = !PAR_EN && (cnt == CNT_PEN);
                    end else if (PAR_EN) begin
                        state_n   = PARITY;
                        x_n       = acc;
                        x_valid_n = 1'b1;
                        last_n    = 1'b1;
                    end else begin
                        state_n = IDLE;
                    end
                end
                PARITY:  state_n = IDLE;
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            sreg    <= '0;
            cnt     <= '0;
            acc     <= 1'b0;
            x       <= 1'b0;
            x_valid <= 1'b0;
            last    <= 1'b0;
        end else begin
            state   <= state_n;
            sreg    <= sreg_n;
            cnt     <= cnt_n;
            acc     <= acc_n;
            x       <= x_n;
            x_valid <= x_valid_n;
            last    <= last_n;
        end
    end

endmodule
